// File: rtl/pipeline_stage_buffer.sv
// pipeline_stage_buffer: registered pipeline stage carrying an instruction
// word plus NUM_CH packed data channels, with a valid/ready handshake on
// both sides and a running count of completed output transfers.
// Optional build macro: PIPELINE_STAGE_SKID_EN adds a second (skid) entry
// so in_ready becomes a registered signal; without it the stage holds one
// word and in_ready is derived combinationally from out_ready.
module pipeline_stage_buffer #(
    parameter int DATA_W  = 20,
    parameter int NUM_CH  = 4,
    parameter int INSTR_W = 20
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [1:0]               occupancy,
    output logic [15:0]              xfer_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                    state_q;
    logic [INSTR_W-1:0]        main_instr_q;
    logic [NUM_CH*DATA_W-1:0]  main_data_q;
    logic [15:0]               xfer_q;
    logic [15:0]               xfer_d;
    logic                      accept;
    logic                      consume;

`ifdef PIPELINE_STAGE_SKID_EN
    logic [INSTR_W-1:0]        skid_instr_q;
    logic [NUM_CH*DATA_W-1:0]  skid_data_q;
    logic                      in_ready_q;

    assign in_ready = in_ready_q;
`else
    assign in_ready = (state_q == ST_EMPTY) || out_ready;
`endif

    assign out_valid  = (state_q != ST_EMPTY);
    assign occupancy  = state_q;
    assign out_instr  = main_instr_q;
    assign out_data   = main_data_q;
    assign xfer_count = xfer_q;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // Transfer counter next value; flush does not suppress the count.
    always_comb begin
        xfer_d = xfer_q;
        if (consume) begin
            xfer_d = xfer_q + 16'd1;
        end
    end

    // Occupancy FSM with its data registers; reset beats flush beats handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= '0;
            main_data_q  <= '0;
            xfer_q       <= '0;
`ifdef PIPELINE_STAGE_SKID_EN
            skid_instr_q <= '0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
`endif
        end else begin
            xfer_q <= xfer_d;
            if (flush) begin
                state_q      <= ST_EMPTY;
                main_instr_q <= '0;
                main_data_q  <= '0;
`ifdef PIPELINE_STAGE_SKID_EN
                skid_instr_q <= '0;
                skid_data_q  <= '0;
                in_ready_q   <= 1'b1;
`endif
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_instr_q <= in_instr;
                            main_data_q  <= in_data;
                            state_q      <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (accept && consume) begin
                            main_instr_q <= in_instr;
                            main_data_q  <= in_data;
`ifdef PIPELINE_STAGE_SKID_EN
                        end else if (accept) begin
                            skid_instr_q <= in_instr;
                            skid_data_q  <= in_data;
                            state_q      <= ST_TWO;
                            in_ready_q   <= 1'b0;
`endif
                        end else if (consume) begin
                            state_q <= ST_EMPTY;
                        end
                    end
`ifdef PIPELINE_STAGE_SKID_EN
                    ST_TWO: begin
                        if (consume) begin
                            main_instr_q <= skid_instr_q;
                            main_data_q  <= skid_data_q;
                            state_q      <= ST_ONE;
                            in_ready_q   <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_q <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Testbench for pipeline_stage_buffer: directed vector table, directed
// corner sequences and randomized traffic against a queue-based model.
module tb_pipeline_stage_buffer;

    localparam int DW = 20;
    localparam int NC = 4;
    localparam int IW = 20;
    localparam int DA = DW * NC;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_instr = '0;
    logic [DA-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_instr;
    logic [DA-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   xfer_count;

    pipeline_stage_buffer #(.DATA_W(DW), .NUM_CH(NC), .INSTR_W(IW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_data(out_data),
        .occupancy(occupancy), .xfer_count(xfer_count)
    );

    always #5 clock = ~clock;

    // Model: FIFO of words currently held, capacity 2 with skid, else 1.
    typedef struct {
        logic [IW-1:0] i;
        logic [DA-1:0] d;
    } ent_t;
    ent_t        mq[$];
    int unsigned m_xfer = 0;
    bit          m_zero = 1'b1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic bit model_in_ready(input bit ordy);
`ifdef PIPELINE_STAGE_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || ordy;
`endif
    endfunction

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    // Apply one cycle of inputs, advance the model across the edge, settle.
    task automatic drive(input bit rst, input bit fl, input bit iv, input bit ordy,
                         input logic [IW-1:0] ins, input logic [DA-1:0] dat);
        bit acc, con;
        ent_t e;
        reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
        in_instr = ins; in_data = dat;
        acc = iv && model_in_ready(ordy);
        con = (mq.size() != 0) && ordy;
        @(posedge clock);
        if (rst) begin
            mq.delete(); m_xfer = 0; m_zero = 1'b1;
        end else begin
            if (con) m_xfer = (m_xfer + 1) % 65536;
            if (fl) begin
                mq.delete(); m_zero = 1'b1;
            end else begin
                if (con) void'(mq.pop_front());
                if (acc) begin
                    e.i = ins; e.d = dat;
                    mq.push_back(e);
                    m_zero = 1'b0;
                end
            end
        end
        #1;
    endtask

    function automatic void check_model(input string tag);
        check({tag, ".valid"}, out_valid, mq.size() != 0);
        check({tag, ".occ"}, occupancy, mq.size());
        check({tag, ".xfer"}, xfer_count, m_xfer);
        check({tag, ".in_ready"}, in_ready, model_in_ready(out_ready));
        if (mq.size() != 0) begin
            check({tag, ".instr"}, out_instr, mq[0].i);
            check({tag, ".data"}, out_data, mq[0].d);
        end else if (m_zero) begin
            check({tag, ".instr0"}, out_instr, 0);
            check({tag, ".data0"}, out_data, 0);
        end
    endfunction

    typedef struct {
        bit            rst, fl, iv;
        logic [IW-1:0] ins;
        logic [DA-1:0] dat;
        bit            e_valid;
        logic [1:0]    e_occ;
        logic [IW-1:0] e_instr;
        logic [DA-1:0] e_data;
        logic [15:0]   e_xfer;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit fl, input bit iv,
                                input logic [IW-1:0] ins, input logic [DA-1:0] dat,
                                input bit ev, input logic [1:0] eo,
                                input logic [IW-1:0] ei, input logic [DA-1:0] ed,
                                input logic [15:0] ex);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ins = ins; v.dat = dat;
        v.e_valid = ev; v.e_occ = eo; v.e_instr = ei; v.e_data = ed; v.e_xfer = ex;
        return v;
    endfunction

    vec_t tbl[8];

    initial begin
        logic [DA-1:0] rd;

        // Table: all rows with out_ready=1, so results match either build.
        tbl[0] = mk(1, 0, 0, 20'h0,     80'h0,     0, 0, 20'h0,     80'h0,     16'd0);
        tbl[1] = mk(0, 0, 1, 20'h12345, 80'h00ABC, 1, 1, 20'h12345, 80'h00ABC, 16'd0);
        tbl[2] = mk(0, 0, 1, 20'hB0B0B, 80'h1_2222_3333_4444_5555, 1, 1, 20'hB0B0B, 80'h1_2222_3333_4444_5555, 16'd1);
        tbl[3] = mk(0, 0, 1, 20'hCCCCC, 80'hFFFFF_00000_FFFFF_00001, 1, 1, 20'hCCCCC, 80'hFFFFF_00000_FFFFF_00001, 16'd2);
        tbl[4] = mk(0, 1, 1, 20'hDDDDD, 80'h5A5A5, 0, 0, 20'h0,     80'h0,     16'd3);
        tbl[5] = mk(0, 0, 0, 20'h77777, 80'h77777, 0, 0, 20'h0,     80'h0,     16'd3);
        tbl[6] = mk(0, 0, 1, 20'hEEEEE, 80'h0000F_0000E, 1, 1, 20'hEEEEE, 80'h0000F_0000E, 16'd3);
        tbl[7] = mk(1, 0, 1, 20'hFFFFF, 80'h12345, 0, 0, 20'h0,     80'h0,     16'd0);

        for (int k = 0; k < 8; k++) begin
            drive(tbl[k].rst, tbl[k].fl, tbl[k].iv, 1'b1, tbl[k].ins, tbl[k].dat);
            check($sformatf("tbl%0d.valid", k), out_valid, tbl[k].e_valid);
            check($sformatf("tbl%0d.occ", k), occupancy, tbl[k].e_occ);
            check($sformatf("tbl%0d.instr", k), out_instr, tbl[k].e_instr);
            check($sformatf("tbl%0d.data", k), out_data, tbl[k].e_data);
            check($sformatf("tbl%0d.xfer", k), xfer_count, tbl[k].e_xfer);
            check($sformatf("tbl%0d.in_ready", k), in_ready, 1'b1);
        end

`ifdef PIPELINE_STAGE_SKID_EN
        // Back-pressure fills both entries; A held, then A and B drain in order.
        drive(1, 0, 0, 0, '0, '0);
        drive(0, 0, 1, 0, 20'hAAAAA, 80'hA);
        drive(0, 0, 1, 0, 20'hBBBBB, 80'hB);
        check("skid.occ2", occupancy, 2);
        check("skid.in_ready0", in_ready, 0);
        check("skid.holdA", out_instr, 20'hAAAAA);
        drive(0, 0, 1, 0, 20'h99999, 80'h9);
        check("skid.stillA", out_data, 80'hA);
        drive(0, 0, 0, 1, '0, '0);
        check("skid.B", out_instr, 20'hBBBBB);
        drive(0, 0, 0, 1, '0, '0);
        check("skid.occ0", occupancy, 0);
        check("skid.xfer2", xfer_count, 2);
        // Flush from full with a word on offer: word never appears.
        drive(0, 0, 1, 0, 20'h11111, 80'h1);
        drive(0, 0, 1, 0, 20'h22222, 80'h2);
        check("fl.pre_occ2", occupancy, 2);
        drive(0, 1, 1, 0, 20'h33333, 80'h3);
        check_model("fl2");
        check("fl2.occ0", occupancy, 0);
        check("fl2.instr0", out_instr, 0);
        check("fl2.in_ready1", in_ready, 1);
        drive(0, 0, 0, 0, '0, '0);
        check("fl2.noword", out_valid, 0);
`else
        // Single entry: flush with a word held and another on offer.
        drive(1, 0, 0, 0, '0, '0);
        drive(0, 0, 1, 0, 20'h11111, 80'h1);
        check("fl1.pre_occ1", occupancy, 1);
        check("fl1.in_ready0", in_ready, 0);
        drive(0, 1, 1, 1, 20'h33333, 80'h3);
        check("fl1.occ0", occupancy, 0);
        check("fl1.instr0", out_instr, 0);
        check("fl1.xfer_counts", xfer_count, 1);
        drive(0, 0, 0, 0, '0, '0);
        check("fl1.noword", out_valid, 0);
`endif

        // Streaming 100 words: one transfer per cycle, order preserved.
        drive(1, 0, 0, 0, '0, '0);
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 1, 1, IW'(i + 1), DA'(i * 3));
            check($sformatf("stream%0d.instr", i), out_instr, i + 1);
        end
        drive(0, 0, 0, 1, '0, '0);
        check("stream.xfer100", xfer_count, 100);
        check("stream.empty", out_valid, 0);

        // Randomized traffic against the model.
        drive(1, 0, 0, 0, '0, '0);
        for (int n = 0; n < 3000; n++) begin
            rd = {$urandom, $urandom, $urandom};
            drive(($urandom % 200) == 0, ($urandom % 40) == 0, $urandom % 2,
                  ($urandom % 4) != 0, IW'($urandom), rd);
            check_model("rnd");
        end

        // Counter wrap: 65536 streaming cycles give 65535 transfers.
        drive(1, 0, 0, 0, '0, '0);
        for (int n = 0; n < 65536; n++) begin
            drive(0, 0, 1, 1, IW'(n), DA'(n));
        end
        check("wrap.ffff", xfer_count, 16'hFFFF);
        drive(0, 0, 1, 1, 20'h5, 80'h5);
        check("wrap.zero", xfer_count, 16'h0000);
        check("wrap.occ1", occupancy, 1);
        drive(1, 0, 1, 1, 20'h6, 80'h6);
        check("rst.valid", out_valid, 0);
        check("rst.occ", occupancy, 0);
        check("rst.instr", out_instr, 0);
        check("rst.data", out_data, 0);
        check("rst.xfer", xfer_count, 0);
        check("rst.in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
